// File: rtl/accumulator_arbiter_pkg.sv
// Shared definitions for the accumulator arbiter: FSM state encoding and
// the operation encoding latched at grant time.
package accumulator_arbiter_pkg;

    typedef enum logic [2:0] {
        INIT  = 3'd0,
        IDLE  = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        CLEAR = 3'd4,
        WAITC = 3'd5
    } state_t;

    typedef enum logic {
        OP_INC  = 1'b0,
        OP_LOAD = 1'b1
    } op_t;

endpackage

// File: rtl/arbiter_round_robin.sv
// One-hot grant generator for NUM_REQ requesters.
// Build option: ACCUMULATOR_ARBITER_ROUND_ROBIN_EN selects round-robin
// (pointer moves to grant+1 on each advance); otherwise fixed priority with
// the lowest index winning and no pointer state.
module arbiter_round_robin #(
    parameter int NUM_REQ = 4
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant
);

    logic [NUM_REQ-1:0] pick;
    logic [NUM_REQ:0]   seen;

`ifdef ACCUMULATOR_ARBITER_ROUND_ROBIN_EN
    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]   ptr_reg;
    logic [NUM_REQ-1:0] high_mask;
    logic [NUM_REQ-1:0] masked;
    logic [PTR_W-1:0]   ptr_chain [NUM_REQ+1];

    // Requests at or above the pointer win first; wrap to the full set otherwise.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_mask
        assign high_mask[gi] = (PTR_W'(gi) >= ptr_reg);
    end
    assign masked = req & high_mask;
    assign pick   = (|masked) ? masked : req;

    // Position after the granted requester, wrapping at NUM_REQ.
    assign ptr_chain[0] = '0;
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_next
        assign ptr_chain[gi+1] = ptr_chain[gi] |
                                 (grant[gi] ? PTR_W'((gi + 1) % NUM_REQ) : '0);
    end

    // Pointer register: moves only when a grant is actually taken.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr_reg <= '0;
        end else if (advance && (|req)) begin
            ptr_reg <= ptr_chain[NUM_REQ];
        end
    end
`else
    logic unused_inputs;
    assign unused_inputs = clock ^ reset_n ^ advance;
    assign pick          = req;
`endif

    // Lowest set bit of the candidate vector becomes the grant.
    assign seen[0] = 1'b0;
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant
        assign grant[gi]  = pick[gi] & ~seen[gi];
        assign seen[gi+1] = seen[gi] | pick[gi];
    end

endmodule

// File: rtl/accumulator_binary_arbiter.sv
// Shares one signed accumulator between NUM_REQ requesters: grants one
// request, issues a single-cycle pulse, waits for acc_updated and returns the
// registered result to the granted requester.
// Build option: ACCUMULATOR_ARBITER_ROUND_ROBIN_EN (round-robin vs fixed
// priority grant, implemented in arbiter_round_robin).
// acc_clock_enable of the accumulator is expected to be tied high.
module accumulator_binary_arbiter
    import accumulator_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int WORD_WIDTH = 8,
    parameter int WAIT_LIMIT = 16
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          clear_req,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_load,
    input  logic [NUM_REQ*WORD_WIDTH-1:0] req_value,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [WORD_WIDTH-1:0]         rsp_value,
    output logic                          rsp_overflow,
    output logic                          rsp_carry,
    output logic                          busy,
    output logic                          timeout,
    output logic                          acc_clear,
    output logic                          acc_increment_valid,
    output logic                          acc_load_valid,
    output logic [WORD_WIDTH-1:0]         acc_increment,
    output logic [WORD_WIDTH-1:0]         acc_load_value,
    output logic                          acc_carry_in,
    input  logic [WORD_WIDTH-1:0]         acc_value,
    input  logic                          acc_updated,
    input  logic                          acc_overflow,
    input  logic                          acc_carry_out
);

    localparam int CNT_W = $clog2(WAIT_LIMIT + 1);

    state_t                 state_reg, state_next;
    logic [NUM_REQ-1:0]     grant;
    logic [NUM_REQ-1:0]     grant_reg;
    logic                   take;
    op_t                    op_reg;
    logic [WORD_WIDTH-1:0]  value_reg;
    logic [WORD_WIDTH-1:0]  sel_chain [NUM_REQ+1];
    logic [CNT_W-1:0]       cnt_reg;
    logic                   waiting;
    logic                   limit_hit;
    logic                   issue;
    logic                   timeout_reg;
    logic [NUM_REQ-1:0]     rsp_valid_reg;
    logic [WORD_WIDTH-1:0]  rsp_value_reg;
    logic                   rsp_overflow_reg;
    logic                   rsp_carry_reg;

    arbiter_round_robin #(.NUM_REQ(NUM_REQ)) u_arb (
        .clock   (clock),
        .reset_n (reset_n),
        .req     (req_valid),
        .advance (take),
        .grant   (grant)
    );

    // Operand of the granted requester (grant is one-hot, so OR is a mux).
    assign sel_chain[0] = '0;
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_sel
        assign sel_chain[gi+1] = sel_chain[gi] |
            (grant[gi] ? req_value[gi*WORD_WIDTH +: WORD_WIDTH] : '0);
    end

    assign waiting   = (state_reg == WAIT) || (state_reg == WAITC);
    assign limit_hit = waiting && !acc_updated &&
                       (cnt_reg == CNT_W'(WAIT_LIMIT - 1));

    // Next-state logic; a grant is taken only in IDLE when no clear is requested.
    always_comb begin
        state_next = state_reg;
        take       = 1'b0;
        case (state_reg)
            INIT:  state_next = WAITC;
            IDLE: begin
                if (clear_req) begin
                    state_next = CLEAR;
                end else if (|req_valid) begin
                    take       = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: state_next = WAIT;
            WAIT, WAITC: begin
                if (acc_updated || limit_hit) state_next = IDLE;
            end
            CLEAR: state_next = WAITC;
            default: state_next = INIT;
        endcase
    end

    // Accumulator controls are decoded from state. The INIT clear is gated by
    // reset_n so every output stays low while reset is held and the clear
    // pulse lands in the first cycle after release.
    assign issue               = (state_reg == ISSUE);
    assign acc_clear           = reset_n && ((state_reg == INIT) || (state_reg == CLEAR));
    assign acc_load_valid      = issue && (op_reg == OP_LOAD);
    assign acc_increment_valid = issue && (op_reg == OP_INC);
    assign acc_load_value      = acc_load_valid ? value_reg : '0;
    assign acc_increment       = acc_increment_valid ? value_reg : '0;
    assign acc_carry_in        = 1'b0;
    assign req_ready           = take ? grant : '0;
    assign busy                = reset_n && (state_reg != IDLE);
    assign timeout             = timeout_reg;
    assign rsp_valid           = rsp_valid_reg;
    assign rsp_value           = rsp_value_reg;
    assign rsp_overflow        = rsp_overflow_reg;
    assign rsp_carry           = rsp_carry_reg;

    // FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_reg <= INIT;
        else          state_reg <= state_next;
    end

    // Latch grant, operation and operand at the handshake.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            grant_reg <= '0;
            op_reg    <= OP_INC;
            value_reg <= '0;
        end else if (take) begin
            grant_reg <= grant;
            op_reg    <= op_t'(|(req_load & grant));
            value_reg <= sel_chain[NUM_REQ];
        end
    end

    // Wait-cycle counter: runs only in WAIT/WAITC, so it is zero on every entry.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)     cnt_reg <= '0;
        else if (waiting) cnt_reg <= cnt_reg + 1'b1;
        else              cnt_reg <= '0;
    end

    // Response pulse, registered result and sticky timeout flag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid_reg    <= '0;
            rsp_value_reg    <= '0;
            rsp_overflow_reg <= 1'b0;
            rsp_carry_reg    <= 1'b0;
            timeout_reg      <= 1'b0;
        end else begin
            rsp_valid_reg <= '0;
            if (state_reg == IDLE && clear_req) begin
                timeout_reg <= 1'b0;
            end
            if (state_reg == WAIT && acc_updated) begin
                rsp_valid_reg    <= grant_reg;
                rsp_value_reg    <= acc_value;
                rsp_overflow_reg <= acc_overflow;
                rsp_carry_reg    <= acc_carry_out;
            end else if (state_reg == WAIT && limit_hit) begin
                rsp_valid_reg    <= grant_reg;
                rsp_value_reg    <= '0;
                rsp_overflow_reg <= 1'b0;
                rsp_carry_reg    <= 1'b0;
            end
            if (limit_hit) begin
                timeout_reg <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_accumulator_binary_arbiter.sv
// Directed bench for accumulator_binary_arbiter with a behavioural
// accumulator (2 extra pipe stages, updated 3 cycles after the pulse) and a
// switch that suppresses acc_updated to exercise the WAIT timeout.
module tb_accumulator_binary_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             clear_req = 1'b0;
    logic [N-1:0]     req_valid = '0;
    logic [N-1:0]     req_ready;
    logic [N-1:0]     req_load = '0;
    logic [N*W-1:0]   req_value = '0;
    logic [N-1:0]     rsp_valid;
    logic [W-1:0]     rsp_value;
    logic             rsp_overflow, rsp_carry, busy, timeout;
    logic             acc_clear, acc_increment_valid, acc_load_valid, acc_carry_in;
    logic [W-1:0]     acc_increment, acc_load_value, acc_value;
    logic             acc_updated, acc_overflow, acc_carry_out;

    int check_count = 0;
    int pass_count  = 0;
    logic stub = 1'b0;

    always #5 clock = ~clock;

    accumulator_binary_arbiter #(.NUM_REQ(N), .WORD_WIDTH(W), .WAIT_LIMIT(16)) dut (
        .clock(clock), .reset_n(reset_n), .clear_req(clear_req),
        .req_valid(req_valid), .req_ready(req_ready), .req_load(req_load),
        .req_value(req_value), .rsp_valid(rsp_valid), .rsp_value(rsp_value),
        .rsp_overflow(rsp_overflow), .rsp_carry(rsp_carry), .busy(busy),
        .timeout(timeout), .acc_clear(acc_clear),
        .acc_increment_valid(acc_increment_valid), .acc_load_valid(acc_load_valid),
        .acc_increment(acc_increment), .acc_load_value(acc_load_value),
        .acc_carry_in(acc_carry_in), .acc_value(acc_value),
        .acc_updated(acc_updated), .acc_overflow(acc_overflow),
        .acc_carry_out(acc_carry_out)
    );

    // Behavioural accumulator: one compute stage plus two pipe stages.
    logic [W-1:0] m_acc = 8'h5A, p1_val = 8'h5A, p2_val = 8'h5A;
    logic m_ovf = 0, m_cy = 0, m_upd = 0;
    logic p1_ovf = 0, p1_cy = 0, p1_upd = 0, p2_ovf = 0, p2_cy = 0, p2_upd = 0;
    logic [W:0] m_sum;
    assign m_sum = {1'b0, m_acc} + {1'b0, acc_increment} + {{W{1'b0}}, acc_carry_in};

    always @(posedge clock) begin
        m_upd <= acc_clear | acc_load_valid | acc_increment_valid;
        if (acc_clear) begin
            m_acc <= '0; m_ovf <= 1'b0; m_cy <= 1'b0;
        end else if (acc_load_valid) begin
            m_acc <= acc_load_value; m_ovf <= 1'b0; m_cy <= 1'b0;
        end else if (acc_increment_valid) begin
            m_acc <= m_sum[W-1:0];
            m_cy  <= m_sum[W];
            m_ovf <= (m_acc[W-1] == acc_increment[W-1]) && (m_sum[W-1] != m_acc[W-1]);
        end
        p1_val <= m_acc;  p1_ovf <= m_ovf;  p1_cy <= m_cy;  p1_upd <= m_upd;
        p2_val <= p1_val; p2_ovf <= p1_ovf; p2_cy <= p1_cy; p2_upd <= p1_upd;
    end

    assign acc_value     = p2_val;
    assign acc_overflow  = p2_ovf;
    assign acc_carry_out = p2_cy;
    assign acc_updated   = p2_upd & ~stub;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_count++;
        assert (obs === exp) pass_count++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    // Ticks until a response appears; lat counts cycles from the grant cycle.
    task automatic wait_rsp(input int start, output int lat);
        lat = start;
        while (rsp_valid == '0 && lat < 40) begin
            tick();
            lat++;
        end
        chk("rsp_seen", (rsp_valid != '0), 1);
    endtask

    // One request from an IDLE negedge through its response.
    task automatic do_req(input int idx, input logic ld, input logic [W-1:0] v,
                          input logic [W-1:0] exp_v, input logic exp_o,
                          input logic exp_c, input int exp_lat);
        int lat;
        req_valid[idx] = 1'b1;
        req_load[idx]  = ld;
        req_value[idx*W +: W] = v;
        #1;
        chk($sformatf("ready_r%0d", idx), req_ready, 32'(1 << idx));
        tick();
        req_valid[idx] = 1'b0;
        wait_rsp(1, lat);
        chk($sformatf("rsp_vec_r%0d", idx), rsp_valid, 32'(1 << idx));
        chk($sformatf("rsp_value_r%0d", idx), rsp_value, exp_v);
        chk($sformatf("rsp_ovf_r%0d", idx), rsp_overflow, exp_o);
        chk($sformatf("rsp_carry_r%0d", idx), rsp_carry, exp_c);
        chk($sformatf("rsp_latency_r%0d", idx), lat, exp_lat);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, n, clr_pulses, rsp_seen, exp_g;

        // Reset held: every output low.
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_acc_clear", acc_clear, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_issue", {acc_load_valid, acc_increment_valid}, 0);

        // Release: one clear pulse, busy until the accumulator answers.
        reset_n = 1'b1;
        #1;
        chk("init_clear", acc_clear, 1);
        chk("init_busy", busy, 1);
        clr_pulses = 1;
        n = 0;
        while (busy && n < 30) begin
            tick(); #1;
            if (acc_clear) clr_pulses++;
            n++;
        end
        chk("init_clear_pulses", clr_pulses, 1);
        chk("init_idle", busy, 0);
        chk("init_acc_zero", acc_value, 0);

        // Increments, load, signed overflow and carry-out.
        do_req(0, 1'b0, 8'd5,   8'd5,   1'b0, 1'b0, 5);
        do_req(2, 1'b0, 8'd3,   8'd8,   1'b0, 1'b0, 5);
        do_req(1, 1'b1, 8'd127, 8'd127, 1'b0, 1'b0, 5);
        do_req(1, 1'b0, 8'd1,   8'h80,  1'b1, 1'b0, 5);
        do_req(3, 1'b0, 8'h80,  8'h00,  1'b1, 1'b1, 5);

        // All four requesting loads of 10*(i+1); pointer is back at 0 here.
        req_valid = 4'hF;
        req_load  = 4'hF;
        req_value = {8'd40, 8'd30, 8'd20, 8'd10};
        for (int k = 0; k < 5; k++) begin
`ifdef ACCUMULATOR_ARBITER_ROUND_ROBIN_EN
            exp_g = k % N;
`else
            exp_g = 0;
`endif
            #1;
            n = 0;
            while (req_ready == '0 && n < 10) begin
                tick(); #1;
                n++;
            end
            chk($sformatf("arb_grant_%0d", k), req_ready, 32'(1 << exp_g));
            tick();
            wait_rsp(1, lat);
            chk($sformatf("arb_rsp_vec_%0d", k), rsp_valid, 32'(1 << exp_g));
            chk($sformatf("arb_rsp_value_%0d", k), rsp_value, 32'(10 * (exp_g + 1)));
        end
        req_valid = '0;
        req_load  = '0;

        // clear_req held 4 cycles with req3 pending: one clear, then req3 served.
        req_value[3*W +: W] = 8'd7;
        req_valid[3] = 1'b1;
        clear_req = 1'b1;
        #1;
        chk("clr_ready_blocked", req_ready, 0);
        clr_pulses = 0;
        rsp_seen = 0;
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c == 4) clear_req = 1'b0;
            #1;
            if (acc_clear) clr_pulses++;
            if (rsp_valid != '0) rsp_seen++;
        end
        n = 0;
        while (req_ready == '0 && n < 20) begin
            tick(); #1;
            if (acc_clear) clr_pulses++;
            if (rsp_valid != '0) rsp_seen++;
            n++;
        end
        chk("clr_pulses", clr_pulses, 1);
        chk("clr_no_rsp", rsp_seen, 0);
        chk("clr_acc_zero", acc_value, 0);
        chk("clr_then_grant3", req_ready, 32'h8);
        tick();
        req_valid[3] = 1'b0;
        wait_rsp(1, lat);
        chk("clr_rsp_vec", rsp_valid, 32'h8);
        chk("clr_rsp_value", rsp_value, 7);
        chk("clr_rsp_latency", lat, 5);

        // acc_updated suppressed: 16 WAIT cycles then timeout with value 0.
        stub = 1'b1;
        do_req(0, 1'b0, 8'd1, 8'd0, 1'b0, 1'b0, 18);
        chk("to_flag", timeout, 1);
        chk("to_idle", busy, 0);
        stub = 1'b0;
        tick();
        chk("to_sticky", timeout, 1);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        chk("to_cleared", timeout, 0);
        n = 0;
        while (busy && n < 30) begin
            tick();
            n++;
        end
        chk("to_clear_idle", busy, 0);
        chk("to_clear_acc_zero", acc_value, 0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
